// File: rtl/cpu_pkg.sv
// Shared constants and types for the register writeback path.
// Requester ids double as bit positions in the arbiter request/grant vectors.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: bit 0 is EX, bit 1 is MEM.
// Ready equals grant, so every grant is a completed handshake and updates the history.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_e last_grant;
  req_id_e last_grant_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_MEM;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    grant          = 2'b00;
    last_grant_nxt = last_grant;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      last_grant_nxt = REQ_EX;
    end else if (grant[1]) begin
      last_grant_nxt = REQ_MEM;
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Arbitrates EX/MEM writebacks onto the single regfile write port (one cycle registered)
// and keeps the per-register busy scoreboard used by decode for RAW/WAW stalls.
module reg_wb_scheduler #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [AW-1:0]        ex_rd,
  input  logic [XLEN-1:0]      ex_data,
  output logic                 ex_ready,
  input  logic                 mem_valid,
  input  logic [AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 mem_ready,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_rd,
  output logic                 alloc_ready,
  input  logic [AW-1:0]        rs_a,
  input  logic [AW-1:0]        rs_b,
  output logic                 stall,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rw,
  output logic [XLEN-1:0]      rf_busw
);
  import cpu_pkg::*;

  localparam int NUM_REGS = 1 << AW;

  logic [1:0]          req_valid;
  logic [1:0]          grant;
  logic                wb_fire;
  logic                wb_write;
  logic [AW-1:0]       sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic                alloc_fire;
  logic                commit_clear;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  assign req_valid = {mem_valid, ex_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .grant (grant)
  );

  assign ex_ready  = grant[0];
  assign mem_ready = grant[1];
  assign wb_fire   = |grant;

  always_comb begin
    sel_rd   = ex_rd;
    sel_data = ex_data;
    if (grant[1]) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // x0 writes are accepted but never reach the port.
  assign wb_write = wb_fire && (sel_rd != REG_ZERO);

  // rf_rw/rf_busw only move on a real write so the port holds steady otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rw   <= REG_ZERO;
      rf_busw <= '0;
    end else begin
      rf_we <= wb_write;
      if (wb_write) begin
        rf_rw   <= sel_rd;
        rf_busw <= sel_data;
      end
    end
  end

  assign alloc_ready  = (alloc_rd == REG_ZERO) || !busy_q[alloc_rd];
  assign alloc_fire   = alloc_valid && alloc_ready && (alloc_rd != REG_ZERO);
  assign commit_clear = rf_we && (rf_rw != REG_ZERO);

  // Clear applies on the regfile commit edge; a same-edge set is applied last and wins.
  always_comb begin
    busy_nxt = busy_q;
    if (commit_clear) begin
      busy_nxt[rf_rw] = 1'b0;
    end
    if (alloc_fire) begin
      busy_nxt[alloc_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the scoreboard is a control flag vector read straight out of reset, so unlike
  // pure data storage it must be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy  = busy_q;
  assign stall = ((rs_a != REG_ZERO) && busy_q[rs_a]) ||
                 ((rs_b != REG_ZERO) && busy_q[rs_b]);

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Self-checking bench for reg_wb_scheduler: a reference arbiter predicts each accepted
// writeback, queues the expected port value, and compares it one cycle later.
module tb_reg_wb_scheduler;
  import cpu_pkg::*;

  typedef struct {
    logic            we;
    logic [AW-1:0]   rw;
    logic [XLEN-1:0] data;
  } wb_t;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic [AW-1:0]     ex_rd;
  logic [XLEN-1:0]   ex_data;
  logic              ex_ready;
  logic              mem_valid;
  logic [AW-1:0]     mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              mem_ready;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_rd;
  logic              alloc_ready;
  logic [AW-1:0]     rs_a;
  logic [AW-1:0]     rs_b;
  logic              stall;
  logic [(1<<AW)-1:0] busy;
  logic              rf_we;
  logic [AW-1:0]     rf_rw;
  logic [XLEN-1:0]   rf_busw;

  int      errors = 0;
  int      checks = 0;
  wb_t     sb[$];
  req_id_e exp_last = REQ_MEM;
  logic    last_ex_g = 1'b0;
  logic    last_mem_g = 1'b0;

  reg_wb_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_data     (ex_data),
    .ex_ready    (ex_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .stall       (stall),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_rw       (rf_rw),
    .rf_busw     (rf_busw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One clock: predict the grant, check ready, queue the expected port value, then
  // advance past the edge and compare the port against the oldest queued entry.
  task automatic tick();
    wb_t  e;
    logic ex_g;
    logic mem_g;
    #1;
    ex_g  = ex_valid && (!mem_valid || exp_last == REQ_MEM);
    mem_g = mem_valid && !ex_g;
    if (!rst) begin
      checks++;
      if (ex_ready !== ex_g || mem_ready !== mem_g) begin
        errors++;
        $display("FAIL arb_grant: got ex_ready=%b mem_ready=%b, expected %b %b",
                 ex_ready, mem_ready, ex_g, mem_g);
      end
    end
    e.we = 1'b0; e.rw = '0; e.data = '0;
    if (rst) begin
      exp_last = REQ_MEM;
    end else if (ex_g) begin
      e.we = (ex_rd != 0); e.rw = ex_rd; e.data = ex_data; exp_last = REQ_EX;
    end else if (mem_g) begin
      e.we = (mem_rd != 0); e.rw = mem_rd; e.data = mem_data; exp_last = REQ_MEM;
    end
    last_ex_g  = ex_g;
    last_mem_g = mem_g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (rf_we !== e.we) begin
      errors++;
      $display("FAIL rf_we: got %b, expected %b", rf_we, e.we);
    end
    if (e.we) begin
      checks++;
      if (rf_rw !== e.rw || rf_busw !== e.data) begin
        errors++;
        $display("FAIL rf_write: got rw=%0d busw=%h, expected rw=%0d busw=%h",
                 rf_rw, rf_busw, e.rw, e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h11;
    tick();
    tick();
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL reset_busy: got %h, expected 0", busy);
    end
    rst = 1'b0;
    tick();
    ex_valid = 1'b0;
    tick();
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL unreserved_write_busy: got %h, expected 0", busy);
    end
  endtask

  task automatic test_conflict();
    logic [2:0] exp_ex = 3'b101;
    rst = 1'b1; tick(); rst = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ex_ready !== exp_ex[i] || mem_ready !== !exp_ex[i]) begin
        errors++;
        $display("FAIL conflict_grant%0d: got ex=%b mem=%b, expected ex=%b mem=%b",
                 i, ex_ready, mem_ready, exp_ex[i], !exp_ex[i]);
      end
      tick();
    end
    ex_valid = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs_a = 5'd7; rs_b = 5'd0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_c0: got alloc_ready=%b stall=%b, expected 1 0", alloc_ready, stall);
    end
    tick();
    alloc_valid = 1'b0;
    #1;
    checks++;
    if (busy[7] !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_c1: got busy7=%b stall=%b, expected 1 1", busy[7], stall);
    end
    tick();
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h77;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_c3: got stall=%b, expected 1", stall);
    end
    tick();
    ex_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || busy[7] !== 1'b1) begin
      errors++;
      $display("FAIL raw_c4: got stall=%b busy7=%b, expected 1 1", stall, busy[7]);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || busy[7] !== 1'b0) begin
      errors++;
      $display("FAIL raw_c5: got stall=%b busy7=%b, expected 0 0", stall, busy[7]);
    end
    rs_a = 5'd0;
  endtask

  task automatic test_waw();
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick();
    checks++;
    if (busy[9] !== 1'b1 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_reserved: got busy9=%b alloc_ready=%b, expected 1 0", busy[9], alloc_ready);
    end
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_before_commit: got alloc_ready=%b, expected 0", alloc_ready);
    end
    tick();
    checks++;
    if (busy[9] !== 1'b0 || alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_after_commit: got busy9=%b alloc_ready=%b, expected 0 1", busy[9], alloc_ready);
    end
    tick();
    checks++;
    if (busy[9] !== 1'b1) begin
      errors++;
      $display("FAIL waw_reset_bit: got busy9=%b, expected 1", busy[9]);
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_x0();
    logic [(1<<AW)-1:0] busy_before;
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFF_FFFF;
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    rs_a = 5'd0; rs_b = 5'd0;
    #1;
    busy_before = busy;
    checks++;
    if (alloc_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_comb: got alloc_ready=%b stall=%b, expected 1 0", alloc_ready, stall);
    end
    tick();
    ex_valid = 1'b0; alloc_valid = 1'b0;
    checks++;
    if (busy !== busy_before || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_busy: got %h, expected %h", busy, busy_before);
    end
    rs_b = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rs_b_stall: got %b, expected 1", stall);
    end
    rs_b = 5'd0;
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h33;
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %h, expected 0", busy);
    end
    rst = 1'b0; ex_valid = 1'b0; alloc_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      ex_valid  = (i % 2 == 0);
      mem_valid = (i % 2 == 1);
      ex_rd  = AW'(i + 1);  ex_data  = 32'h1000 + i;
      mem_rd = AW'(i + 10); mem_data = 32'h2000 + i;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      if (!(ex_valid && !last_ex_g)) begin
        ex_valid = 1'($urandom_range(0, 1));
        ex_rd    = AW'($urandom_range(0, 31));
        ex_data  = $urandom;
      end
      if (!(mem_valid && !last_mem_g)) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_rd    = AW'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      tick();
    end
    ex_valid = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0;
    rs_a = '0; rs_b = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_conflict();
    test_raw();
    test_waw();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
